// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array feed controller.
package systolic_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FEED  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } feed_state_t;

    // Cycles spent draining: row skew plus propagation through the array.
    function automatic int drain_len(input int n);
        return n + n;
    endfunction

endpackage

// File: rtl/systolic_feed_ctrl_skew_shift.sv
// Row-valid skew chain: tap r carries the input delayed by r+1 cycles.
module skew_shift #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         d,
    output logic [N-1:0] q
);

    logic [N-1:0] r_sh;

    // Shift register, cleared synchronously.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh <= '0;
        end else begin
            r_sh <= {r_sh[N-2:0], d};
        end
    end

    assign q = r_sh;

endmodule

// File: rtl/systolic_feed_ctrl.sv
// Feed controller for an N-row systolic array: reads K operand words per job,
// skews row valids, drains, then pulses done. Optional SYSTOLIC_FEED_PERF_EN adds perf_cycles.
module systolic_feed_ctrl
    import systolic_pkg::*;
#(
    parameter int N  = 4,
    parameter int K  = 4,
    parameter int AW = (K > 1) ? $clog2(K) : 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    output logic          busy,
    output logic          done,
    output logic          acc_clr,
    output logic          rd_en,
    output logic [AW-1:0] rd_addr,
    output logic [N-1:0]  row_vld
`ifdef SYSTOLIC_FEED_PERF_EN
    ,
    output logic [31:0]   perf_cycles
`endif
);

    localparam int FCW       = $clog2(K + 1);
    localparam int DRAIN_CYC = drain_len(N);
    localparam int DCW       = $clog2(DRAIN_CYC + 1);
    localparam logic [FCW-1:0] FEED_END  = FCW'(K);
    localparam logic [DCW-1:0] DRAIN_END = DCW'(DRAIN_CYC);

    feed_state_t     r_state;
    logic            r_busy;
    logic            r_done;
    logic            r_acc_clr;
    logic            r_rd_en;
    logic [AW-1:0]   r_rd_addr;
    logic [FCW-1:0]  r_feed_cnt;
    logic [DCW-1:0]  r_drain_cnt;
    logic            w_kill;
    logic            w_skew_clr;

    assign w_kill     = abort && (r_state != IDLE);
    assign w_skew_clr = rst || w_kill;

    // Job sequencing FSM; all outputs registered. Counters hold the number of
    // cycles already spent in the current state, reloaded to 1 on entry.
    always_ff @(posedge clk) begin
        if (rst || w_kill) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_acc_clr   <= 1'b0;
            r_rd_en     <= 1'b0;
            r_rd_addr   <= '0;
            r_feed_cnt  <= '0;
            r_drain_cnt <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done    <= 1'b0;
                    r_rd_addr <= '0;
                    if (start && !abort) begin
                        r_state    <= FEED;
                        r_busy     <= 1'b1;
                        r_acc_clr  <= 1'b1;
                        r_rd_en    <= 1'b1;
                        r_feed_cnt <= FCW'(1);
                    end else begin
                        r_state    <= IDLE;
                        r_busy     <= 1'b0;
                        r_acc_clr  <= 1'b0;
                        r_rd_en    <= 1'b0;
                        r_feed_cnt <= '0;
                    end
                end
                FEED: begin
                    r_acc_clr <= 1'b0;
                    if (r_feed_cnt == FEED_END) begin
                        r_state     <= DRAIN;
                        r_rd_en     <= 1'b0;
                        r_rd_addr   <= '0;
                        r_feed_cnt  <= '0;
                        r_drain_cnt <= DCW'(1);
                    end else begin
                        r_rd_addr  <= AW'(r_feed_cnt);
                        r_feed_cnt <= r_feed_cnt + FCW'(1);
                    end
                end
                DRAIN: begin
                    if (r_drain_cnt == DRAIN_END) begin
                        r_state     <= DONE;
                        r_done      <= 1'b1;
                        r_drain_cnt <= '0;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DCW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state     <= IDLE;
                    r_busy      <= 1'b0;
                    r_done      <= 1'b0;
                    r_acc_clr   <= 1'b0;
                    r_rd_en     <= 1'b0;
                    r_rd_addr   <= '0;
                    r_feed_cnt  <= '0;
                    r_drain_cnt <= '0;
                end
            endcase
        end
    end

    // Buffer read latency plus per-row skew come from one shared chain.
    skew_shift #(
        .N (N)
    ) u_skew (
        .clk (clk),
        .rst (w_skew_clr),
        .d   (r_rd_en),
        .q   (row_vld)
    );

    assign busy    = r_busy;
    assign done    = r_done;
    assign acc_clr = r_acc_clr;
    assign rd_en   = r_rd_en;
    assign rd_addr = r_rd_addr;

`ifdef SYSTOLIC_FEED_PERF_EN
    logic [31:0] r_perf;

    // Busy-cycle counter, saturating; only rst clears it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf <= 32'd0;
        end else if (r_busy && (r_perf != 32'hFFFF_FFFF)) begin
            r_perf <= r_perf + 32'd1;
        end else begin
            r_perf <= r_perf;
        end
    end

    assign perf_cycles = r_perf;
`endif

endmodule

// File: tb/tb_systolic_feed_ctrl.sv
// Self-checking bench for systolic_feed_ctrl: directed scenarios plus random
// start/abort/rst traffic against a job-timeline reference model.
module tb_systolic_feed_ctrl;

    localparam int N       = 4;
    localparam int K       = 4;
    localparam int AW      = $clog2(K);
    localparam int JOB_LEN = K + 2 * N + 1;

    logic          clk;
    logic          rst;
    logic          start;
    logic          abort;
    logic          busy;
    logic          done;
    logic          acc_clr;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [N-1:0]  row_vld;
`ifdef SYSTOLIC_FEED_PERF_EN
    logic [31:0]   perf_cycles;
`endif

    int n_checks;
    int n_errors;
    int cyc;
    int done_seen;
    bit m_active;
    int m_t0;
    int m_perf;

    systolic_feed_ctrl #(
        .N  (N),
        .K  (K),
        .AW (AW)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .abort   (abort),
        .busy    (busy),
        .done    (done),
        .acc_clr (acc_clr),
        .rd_en   (rd_en),
        .rd_addr (rd_addr),
        .row_vld (row_vld)
`ifdef SYSTOLIC_FEED_PERF_EN
        ,
        .perf_cycles (perf_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock cycle: check outputs against the job timeline, then apply inputs
    // for the coming edge and advance the model.
    task automatic step(input logic s, input logic a, input logic r);
        int d;
        int e;
        bit e_busy;
        bit e_rden;
        logic [N-1:0] e_vld;
        @(negedge clk);
        d      = cyc - m_t0;
        e_busy = m_active && (d >= 1) && (d <= JOB_LEN);
        e_rden = m_active && (d >= 1) && (d <= K);
        for (int i = 0; i < N; i++) begin
            e        = d - 1 - i;
            e_vld[i] = m_active && (e >= 1) && (e <= K);
        end
        check_val("busy",    32'(busy),    32'(e_busy));
        check_val("done",    32'(done),    32'(m_active && (d == JOB_LEN)));
        check_val("acc_clr", 32'(acc_clr), 32'(m_active && (d == 1)));
        check_val("rd_en",   32'(rd_en),   32'(e_rden));
        check_val("rd_addr", 32'(rd_addr), e_rden ? 32'(d - 1) : 32'd0);
        check_val("row_vld", 32'(row_vld), 32'(e_vld));
`ifdef SYSTOLIC_FEED_PERF_EN
        check_val("perf_cycles", perf_cycles, 32'(m_perf));
`endif
        if (done === 1'b1) done_seen++;
        start = s;
        abort = a;
        rst   = r;
        if (r) begin
            m_active = 1'b0;
            m_perf   = 0;
        end else begin
            if (e_busy) m_perf++;
            if (m_active) begin
                if (a || (d == JOB_LEN)) m_active = 1'b0;
            end else if (s && !a) begin
                m_active = 1'b1;
                m_t0     = cyc;
            end
        end
        cyc++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        n_checks  = 0;
        n_errors  = 0;
        cyc       = 0;
        done_seen = 0;
        m_active  = 1'b0;
        m_t0      = 0;
        m_perf    = 0;
        rst   = 1'b1;
        start = 1'b0;
        abort = 1'b0;

        step(1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b1);
        idle(3);

        // Nominal job.
        done_seen = 0;
        step(1'b1, 1'b0, 1'b0);
        idle(16);
        check_val("done_cnt_nominal", 32'(done_seen), 32'd1);

        // Start re-pulsed in FEED, DRAIN and DONE.
        done_seen = 0;
        for (int i = 0; i < 20; i++) begin
            step((i == 0) || (i == 3) || (i == 9) || (i == 13), 1'b0, 1'b0);
        end
        check_val("done_cnt_repulse", 32'(done_seen), 32'd1);

        // Abort during FEED.
        done_seen = 0;
        for (int i = 0; i < 18; i++) step(i == 0, i == 3, 1'b0);
        check_val("done_cnt_abort", 32'(done_seen), 32'd0);

        // Start and abort together in IDLE.
        done_seen = 0;
        step(1'b1, 1'b1, 1'b0);
        idle(4);
        check_val("done_cnt_start_abort", 32'(done_seen), 32'd0);

        // Reset mid-job, then two nominal jobs.
        done_seen = 0;
        for (int i = 0; i < 10; i++) step(i == 0, 1'b0, i == 6);
        check_val("done_cnt_rst", 32'(done_seen), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        idle(15);
        step(1'b1, 1'b0, 1'b0);
        idle(16);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            step($urandom_range(3, 0) == 0, $urandom_range(31, 0) == 0,
                 $urandom_range(127, 0) == 0);
        end
        idle(20);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
